uart_rx18: RTL
==============

# uart_rx18

Receive-side counterpart of the 18-channel 6-bit UART link. Deserialises the 2400-baud serial stream produced by the 18-input transmitter (three 8-bit-time frames per group: start 0, six data bits LSB first, stop 1, followed by an idle gap) and rebuilds the 18-bit sample word. It sits on the host/decoder FPGA behind the serial pin and presents each completed word with a one-cycle valid strobe.

## Interface
- CLKS_PER_BIT, 20833, sys_clk cycles per bit time (50 MHz / 2400); 16-bit counter, legal range 8..65535.
- IDLE_BITS, 4, continuous-high bit times in IDLE that realign the group to frame 0.
- sys_clk  input  1  system clock; all logic on rising edge.
- sys_reset  input  1  asynchronous, active-low reset.
- uart_rxd  input  1  serial line, idle high, asynchronous to sys_clk.
- data_out  output  18  last complete word; bit 0 = channel 1 … bit 17 = channel 18.
- data_valid  output  1  one-cycle pulse when data_out updates.
- frame_err  output  1  one-cycle pulse on bad stop bit or truncated group.
- rx_busy  output  1  high while state != IDLE.

## Operation
- uart_rxd passes through a 2-flop synchroniser (reset value 1); all logic uses the synchronised line rxd_s and its previous value for edge detect.
- States: IDLE, START, DATA, STOP. Bit counter clk_cnt (16 b), data bit index bit_idx (3 b), frame index frame_idx (2 b: 0,1,2), shift register sh[5:0], group buffer grp[11:0].
- IDLE: falling edge of rxd_s -> START, clk_cnt <= 0. Otherwise count consecutive high cycles in idle_cnt (width ceil(log2(IDLE_BITS*CLKS_PER_BIT))+1, saturating).
- IDLE timeout: idle_cnt reaches IDLE_BITS*CLKS_PER_BIT with frame_idx != 0 -> frame_idx <= 0, grp discarded, frame_err pulses. With frame_idx == 0: no action.
- START: at clk_cnt == CLKS_PER_BIT/2 (integer division) sample; 1 -> false start, back to IDLE, no error; 0 -> DATA, clk_cnt <= 0, bit_idx <= 0.
- DATA: sample each time clk_cnt == CLKS_PER_BIT-1 (mid-bit), restart clk_cnt; sh[bit_idx] <= sample; after bit_idx 5 -> STOP.
- STOP: sample at next mid-bit point. 1 -> frame accepted: frame_idx 0 -> grp[5:0] <= sh; 1 -> grp[11:6] <= sh; 2 -> data_out <= {sh, grp}, data_valid pulse, frame_idx <= 0; else frame_idx + 1. 0 -> frame_err pulse, frame_idx <= 0, grp discarded. Either way -> IDLE, idle_cnt <= 0.
- Stop-bit failure and idle timeout never coincide (exclusive states); a new start edge in the same cycle as STOP exit is ignored and seen next falling edge.
- data_out holds until the next complete good group.

## Timing
- Reset: data_out 0, data_valid 0, frame_err 0, rx_busy 0, state IDLE, frame_idx 0, sync flops 1.
- Synchroniser latency 2 cycles; first sample at line-fall + 2 + CLKS_PER_BIT/2 cycles; following samples every CLKS_PER_BIT cycles.
- data_valid / frame_err asserted the cycle after the deciding stop-bit sample, exactly one cycle wide; data_out valid in that same cycle.
- Reset asserted mid-frame: immediate return to reset values; partial group lost.

## Configuration
- UART_RX_MAJORITY_EN defined: each sample (start, data, stop) is the 2-of-3 majority of rxd_s at mid-1, mid, mid+1; decision taken at mid+1, so all flag outputs shift one cycle later.
- Undefined: single sample of rxd_s at mid-bit.

## Test plan (CLKS_PER_BIT=16, IDLE_BITS=4)
- Group 18'h2A5C3 sent as frames 0x03, 0x17, 0x2A back-to-back, then 8 idle bits -> data_out=18'h2A5C3, data_valid one cycle, frame_err never.
- Same group with frame 1 stop bit = 0 -> frame_err one cycle, no data_valid, data_out unchanged; next good group 18'h15A3C decoded exactly.
- 3-cycle low glitch on idle line -> false start, rx_busy returns 0, no flags; with UART_RX_MAJORITY_EN, 1-cycle low glitch at mid of data bit 2 of 0x3F -> still decoded 0x3F.
- Frames 0 and 1 only, then 5 idle bits -> frame_err one cycle at 64 idle cycles; following full group 18'h3FFFF decoded, data_valid once.
- sys_reset pulsed low during frame 2 data bits -> all outputs 0 immediately; next full group 18'h00001 decoded correctly.

Source files
------------

// File: rtl/uart_rx18.sv
// uart_rx18: receiver for the 18-channel 6-bit UART link (3 frames per word).
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority sampling around mid-bit.
module uart_rx18 #(
    parameter int CLKS_PER_BIT = 20833,
    parameter int IDLE_BITS    = 4
) (
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic        uart_rxd,
    output logic [17:0] data_out,
    output logic        data_valid,
    output logic        frame_err,
    output logic        rx_busy
);

    localparam int IDLE_LEN = IDLE_BITS * CLKS_PER_BIT;
    localparam int IW       = $clog2(IDLE_LEN) + 1;
    localparam logic [IW-1:0] IDLE_LIM = IW'(IDLE_LEN);

`ifdef UART_RX_MAJORITY_EN
    localparam int DLY = 1;
`else
    localparam int DLY = 0;
`endif

    // Start check lands on mid (or mid+1 with majority); later bits keep
    // the same offset because they are spaced a full bit apart.
    localparam logic [15:0] START_PT = 16'(CLKS_PER_BIT / 2 + DLY);
    localparam logic [15:0] BIT_PT   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            rxd_s_q;
    logic            rxd_p_q;
    logic [15:0]     clk_cnt_q;
    logic [2:0]      bit_idx_q;
    logic [1:0]      frame_idx_q;
    logic [5:0]      sh_q;
    logic [11:0]     grp_q;
    logic [IW-1:0]   idle_cnt_q;
    logic [IW-1:0]   idle_cnt_d;
    logic [17:0]     data_out_q;
    logic            data_valid_q;
    logic            frame_err_q;
    logic            fall;
    logic            samp;

    assign fall       = rxd_p_q & ~rxd_s_q;
    assign idle_cnt_d = (idle_cnt_q == IDLE_LIM) ? idle_cnt_q
                                                 : idle_cnt_q + IW'(1);

    // Two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            sync1_q <= 1'b1;
            rxd_s_q <= 1'b1;
            rxd_p_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            rxd_s_q <= sync1_q;
            rxd_p_q <= rxd_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxd_p2_q;

    // Extra history tap so mid-1, mid and mid+1 are all visible at mid+1
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            rxd_p2_q <= 1'b1;
        end else begin
            rxd_p2_q <= rxd_p_q;
        end
    end

    assign samp = (rxd_p2_q & rxd_p_q) |
                  (rxd_p_q & rxd_s_q) |
                  (rxd_p2_q & rxd_s_q);
`else
    assign samp = rxd_s_q;
`endif

    // Receive FSM: frame timing, word assembly and registered strobes
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q      <= S_IDLE;
            clk_cnt_q    <= '0;
            bit_idx_q    <= '0;
            frame_idx_q  <= '0;
            sh_q         <= '0;
            grp_q        <= '0;
            idle_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (fall) begin
                        state_q    <= S_START;
                        clk_cnt_q  <= '0;
                        idle_cnt_q <= '0;
                    end else if (rxd_s_q) begin
                        idle_cnt_q <= idle_cnt_d;
                    end else begin
                        idle_cnt_q <= '0;
                    end
                    // A long idle gap drops a partly received group
                    if (idle_cnt_q == IDLE_LIM && frame_idx_q != 2'd0) begin
                        frame_idx_q <= '0;
                        grp_q       <= '0;
                        frame_err_q <= 1'b1;
                    end
                end
                S_START: begin
                    clk_cnt_q <= clk_cnt_q + 16'd1;
                    if (clk_cnt_q == START_PT) begin
                        if (samp) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q   <= S_DATA;
                            clk_cnt_q <= '0;
                            bit_idx_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (clk_cnt_q == BIT_PT) begin
                        clk_cnt_q <= '0;
                        sh_q      <= {samp, sh_q[5:1]};
                        if (bit_idx_q == 3'd5) begin
                            state_q <= S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt_q == BIT_PT) begin
                        clk_cnt_q  <= '0;
                        state_q    <= S_IDLE;
                        idle_cnt_q <= '0;
                        if (samp) begin
                            unique case (frame_idx_q)
                                2'd0: begin
                                    grp_q[5:0]  <= sh_q;
                                    frame_idx_q <= 2'd1;
                                end
                                2'd1: begin
                                    grp_q[11:6] <= sh_q;
                                    frame_idx_q <= 2'd2;
                                end
                                default: begin
                                    data_out_q   <= {sh_q, grp_q};
                                    data_valid_q <= 1'b1;
                                    frame_idx_q  <= 2'd0;
                                end
                            endcase
                        end else begin
                            frame_err_q <= 1'b1;
                            frame_idx_q <= '0;
                            grp_q       <= '0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign rx_busy    = (state_q != S_IDLE);

endmodule
